// File: rtl/rx_host_ctrl.sv
// rx_host_ctrl: sits between the UART receiver and the host.
// It turns each receiver DoneFlag into one FIFO entry {error, data} and
// shows the FIFO to the host through a first-word fall-through valid/ready port.
// It owns the receiver's parity/baud configuration and applies host changes
// only once the serial line has been idle long enough.
// It also keeps sticky overflow status and a saturating errored-frame count.
module rx_host_ctrl #(
  parameter int         DEPTH         = 8,
  parameter int         IDLE_CYCLES   = 16,
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [1:0] DEF_PARITY    = 2'b00,
  parameter logic [1:0] DEF_BAUD      = 2'b10
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     RxLine,
  input  logic                     RxDone,
  input  logic [7:0]               RxData,
  input  logic                     RxError,
  input  logic                     CfgWrite,
  input  logic [1:0]               CfgParity,
  input  logic [1:0]               CfgBaud,
  input  logic                     ClrStatus,
  input  logic                     OutReady,
  output logic [1:0]               ParityType,
  output logic [1:0]               BaudRate,
  output logic                     CfgPending,
  output logic                     OutValid,
  output logic [7:0]               OutData,
  output logic                     OutError,
  output logic [$clog2(DEPTH):0]   FifoCount,
  output logic                     Overflow,
  output logic [7:0]               ErrCount
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int ICW = $clog2(IDLE_CYCLES + 1);
  localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_APPLY  = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  logic           done_s1, done_s2, done_s3;
  logic           line_s1, line_s2;
  logic           push, pop, full, wr_en, ovf_evt;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [8:0]     mem [DEPTH];
  logic [8:0]     head;
  logic [ICW-1:0] idle_cnt;
  logic           idle_clear;
  logic [1:0]     state;
  logic [1:0]     pend_parity, pend_baud;
  logic [SW-1:0]  settle_cnt;

  // Synchronise RxDone and RxLine into the Clock domain.
  // RxDone flops reset high, so a DoneFlag held across reset does not look like a new frame.
  // NOTE: every state register uses non-blocking assignment, so all flops see pre-edge values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      done_s1 <= 1'b1;
      done_s2 <= 1'b1;
      done_s3 <= 1'b1;
      line_s1 <= 1'b0;
      line_s2 <= 1'b0;
    end else begin
      done_s1 <= RxDone;
      done_s2 <= done_s1;
      done_s3 <= done_s2;
      line_s1 <= RxLine;
      line_s2 <= line_s1;
    end
  end

  assign push    = done_s2 & ~done_s3;
  assign full    = (FifoCount == CW'(DEPTH));
  assign pop     = OutValid & OutReady;
  assign wr_en   = push & (~full | pop);
  assign ovf_evt = push & full & ~pop;

  assign head     = mem[rd_ptr];
  assign OutValid = (FifoCount != '0);
  assign OutData  = OutValid ? head[7:0] : 8'h00;
  assign OutError = OutValid & head[8];

  // Entry storage; the receiver holds data/error stable for the whole push cycle.
  // NOTE: the storage array has no reset; occupancy tracking alone decides what is valid.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr] <= {RxError, RxData};
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      FifoCount <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   FifoCount <= FifoCount + 1'b1;
        2'b01:   FifoCount <= FifoCount - 1'b1;
        default: FifoCount <= FifoCount;
      endcase
    end
  end

  // Sticky overflow and saturating error count; a clear beats a same-cycle event.
  always_ff @(posedge Clock) begin
    if (Reset || ClrStatus) begin
      Overflow <= 1'b0;
      ErrCount <= 8'h00;
    end else begin
      if (ovf_evt) Overflow <= 1'b1;
      if (push && RxError && ErrCount != 8'hFF) ErrCount <= ErrCount + 1'b1;
    end
  end

  assign idle_clear = ~line_s2 | push | (state == ST_SETTLE) |
                      ((state == ST_WAIT) & CfgWrite);

  // Count consecutive idle-high cycles of the line, saturating at IDLE_CYCLES.
  always_ff @(posedge Clock) begin
    if (Reset || idle_clear)                   idle_cnt <= '0;
    else if (idle_cnt != ICW'(IDLE_CYCLES))    idle_cnt <= idle_cnt + 1'b1;
  end

  // Config FSM: hold a host request until the line is idle, apply it, then let the receiver settle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      pend_parity <= DEF_PARITY;
      pend_baud   <= DEF_BAUD;
      CfgPending  <= 1'b0;
      ParityType  <= DEF_PARITY;
      BaudRate    <= DEF_BAUD;
      settle_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (CfgWrite) begin
            pend_parity <= CfgParity;
            pend_baud   <= CfgBaud;
            CfgPending  <= 1'b1;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (CfgWrite) begin
            pend_parity <= CfgParity;
            pend_baud   <= CfgBaud;
          end else if (idle_cnt == ICW'(IDLE_CYCLES)) begin
            state <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          ParityType <= pend_parity;
          BaudRate   <= pend_baud;
          CfgPending <= 1'b0;
          settle_cnt <= '0;
          state      <= ST_SETTLE;
        end
        default: begin
          if (CfgWrite) begin
            pend_parity <= CfgParity;
            pend_baud   <= CfgBaud;
            CfgPending  <= 1'b1;
          end
          if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
            settle_cnt <= '0;
            state      <= (CfgPending || CfgWrite) ? ST_WAIT : ST_IDLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_host_ctrl.sv
// Testbench for rx_host_ctrl.
// The bench keeps a queue-based reference model that it updates on every rising edge.
// It compares the model with the DUT outputs on every falling edge.
// Directed scenarios add hand-computed literal expectations on top of that.
module tb_rx_host_ctrl;

  localparam int         DEPTH         = 8;
  localparam int         IDLE_CYCLES   = 16;
  localparam int         SETTLE_CYCLES = 4;
  localparam logic [1:0] DEF_PARITY    = 2'b00;
  localparam logic [1:0] DEF_BAUD      = 2'b10;

  logic       Clock = 1'b0;
  logic       Reset, RxLine, RxDone, RxError, CfgWrite, ClrStatus, OutReady;
  logic [7:0] RxData;
  logic [1:0] CfgParity, CfgBaud;
  logic [1:0] ParityType, BaudRate;
  logic       CfgPending, OutValid, OutError, Overflow;
  logic [7:0] OutData, ErrCount;
  logic [$clog2(DEPTH):0] FifoCount;

  int n_checks = 0;
  int n_pass   = 0;

  rx_host_ctrl #(
    .DEPTH(DEPTH), .IDLE_CYCLES(IDLE_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES),
    .DEF_PARITY(DEF_PARITY), .DEF_BAUD(DEF_BAUD)
  ) dut (
    .Clock(Clock), .Reset(Reset), .RxLine(RxLine), .RxDone(RxDone),
    .RxData(RxData), .RxError(RxError), .CfgWrite(CfgWrite),
    .CfgParity(CfgParity), .CfgBaud(CfgBaud), .ClrStatus(ClrStatus),
    .OutReady(OutReady), .ParityType(ParityType), .BaudRate(BaudRate),
    .CfgPending(CfgPending), .OutValid(OutValid), .OutData(OutData),
    .OutError(OutError), .FifoCount(FifoCount), .Overflow(Overflow),
    .ErrCount(ErrCount)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [8:0] m_q[$];
  bit         m_ok = 0;
  bit         m_ovf, m_pend, m_apply;
  int         m_err, m_ic, m_settle_left;
  logic [1:0] m_par, m_baud, m_pp, m_pb;
  bit         m_d1, m_d2, m_d3, m_l1, m_l2;

  always @(posedge Clock) begin : model
    bit push, pop, full, in_settle, in_wait, ic_clr;
    int old_ic;
    if (Reset) begin
      m_q.delete();
      m_ok = 1; m_ovf = 0; m_err = 0; m_pend = 0; m_apply = 0;
      m_ic = 0; m_settle_left = 0;
      m_par = DEF_PARITY; m_baud = DEF_BAUD;
      m_d1 = 1; m_d2 = 1; m_d3 = 1; m_l1 = 0; m_l2 = 0;
    end else begin
      push = m_d2 && !m_d3;
      full = (m_q.size() == DEPTH);
      pop  = (m_q.size() != 0) && OutReady;
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (!full || pop) m_q.push_back({RxError, RxData});
        else m_ovf = 1;
        if (RxError && m_err < 255) m_err++;
      end
      if (ClrStatus) begin m_ovf = 0; m_err = 0; end

      in_settle = (m_settle_left > 0);
      in_wait   = m_pend && !m_apply && !in_settle;
      ic_clr    = !m_l2 || push || in_settle || (in_wait && CfgWrite);
      old_ic    = m_ic;
      if (ic_clr) m_ic = 0;
      else if (m_ic < IDLE_CYCLES) m_ic++;

      if (m_apply) begin
        m_par = m_pp; m_baud = m_pb; m_pend = 0; m_apply = 0;
        m_settle_left = SETTLE_CYCLES;
      end else if (in_settle) begin
        if (CfgWrite) begin m_pp = CfgParity; m_pb = CfgBaud; m_pend = 1; end
        m_settle_left--;
      end else if (!m_pend) begin
        if (CfgWrite) begin m_pp = CfgParity; m_pb = CfgBaud; m_pend = 1; end
      end else begin
        if (CfgWrite) begin m_pp = CfgParity; m_pb = CfgBaud; end
        else if (old_ic == IDLE_CYCLES) m_apply = 1;
      end

      m_d3 = m_d2; m_d2 = m_d1; m_d1 = RxDone;
      m_l2 = m_l1; m_l1 = RxLine;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clock) begin
    if (m_ok) begin
      check("m_valid",   OutValid,   m_q.size() != 0);
      check("m_data",    OutData,    (m_q.size() != 0) ? m_q[0][7:0] : 8'h00);
      check("m_err_bit", OutError,   (m_q.size() != 0) ? m_q[0][8] : 1'b0);
      check("m_count",   FifoCount,  m_q.size());
      check("m_ovf",     Overflow,   m_ovf);
      check("m_errcnt",  ErrCount,   m_err);
      check("m_parity",  ParityType, m_par);
      check("m_baud",    BaudRate,   m_baud);
      check("m_pending", CfgPending, m_pend);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  // One receiver frame; optional host pop and/or status clear in the push cycle.
  task automatic frame(input logic [7:0] d, input logic e, input logic pop_at_push,
                       input logic clr_at_push);
    RxData = d; RxError = e; RxDone = 1'b1;
    step();
    step();
    if (pop_at_push) OutReady = 1'b1;
    if (clr_at_push) ClrStatus = 1'b1;
    step();
    if (pop_at_push) OutReady = 1'b0;
    ClrStatus = 1'b0;
    step();
    RxDone = 1'b0;
    repeat (3) step();
  endtask

  task automatic toggle_line(input int n);
    for (int i = 0; i < n; i++) begin
      RxLine = (((i / 3) % 2) == 0);
      step();
    end
    RxLine = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] p, input logic [1:0] b);
    CfgParity = p; CfgBaud = b; CfgWrite = 1'b1;
    step();
    CfgWrite = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset = 1; RxLine = 1; RxDone = 0; RxData = 0; RxError = 0; CfgWrite = 0;
    CfgParity = 0; CfgBaud = 0; ClrStatus = 0; OutReady = 0;
    step(); step();
    check("rst_valid",  OutValid,   1'b0);
    check("rst_count",  FifoCount,  0);
    check("rst_parity", ParityType, 2'b00);
    check("rst_baud",   BaudRate,   2'b10);
    check("rst_errcnt", ErrCount,   0);
    Reset = 0;
    repeat (3) step();

    // First frame: OutValid exactly two edges after RxDone is first sampled.
    RxData = 8'hA5; RxError = 0; RxDone = 1;
    step(); check("lat_k",  OutValid, 1'b0);
    step(); check("lat_k1", OutValid, 1'b0);
    step(); check("lat_k2", OutValid, 1'b1);
    check("a5_data",  OutData,   8'hA5);
    check("a5_count", FifoCount, 1);
    RxDone = 0;
    repeat (3) step();
    OutReady = 1;
    step();
    OutReady = 0;
    check("a5_popped", OutValid, 1'b0);

    // Overflow: nine frames into an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b0, 1'b0);
    check("ovf_count", FifoCount, 8);
    check("ovf_flag",  Overflow,  1'b1);
    OutReady = 1;
    for (int i = 1; i <= 8; i++) begin
      check("drain1", OutData, 8'(i));
      step();
    end
    OutReady = 0;
    check("drain1_empty", OutValid, 1'b0);
    ClrStatus = 1; step(); ClrStatus = 0;
    check("ovf_cleared", Overflow, 1'b0);

    // Full FIFO with push and pop together.
    for (int i = 0; i < 8; i++) frame(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    check("full_count", FifoCount, 8);
    frame(8'h20, 1'b0, 1'b1, 1'b0);
    check("pp_count", FifoCount, 8);
    check("pp_ovf",   Overflow,  1'b0);
    OutReady = 1;
    for (int i = 0; i < 8; i++) begin
      check("drain2", OutData, (i < 7) ? 8'h11 + 8'(i) : 8'h20);
      step();
    end
    OutReady = 0;

    // Error count saturation, then clear colliding with an errored push.
    OutReady = 1;
    for (int i = 0; i < 300; i++) frame(8'(i), 1'b1, 1'b0, 1'b0);
    check("err_sat", ErrCount, 255);
    frame(8'h77, 1'b1, 1'b0, 1'b1);
    check("err_clr", ErrCount, 0);
    repeat (2) step();
    OutReady = 0;

    // Config applied only after the line is idle.
    toggle_line(6);
    cfg_write(2'b01, 2'b11);
    toggle_line(30);
    check("cfg_hold_par",  ParityType, 2'b00);
    check("cfg_hold_baud", BaudRate,   2'b10);
    check("cfg_hold_pend", CfgPending, 1'b1);
    RxLine = 1;
    repeat (10) step();
    check("cfg_early_par", ParityType, 2'b00);
    check("cfg_early_pend", CfgPending, 1'b1);
    repeat (15) step();
    check("cfg_app_par",  ParityType, 2'b01);
    check("cfg_app_baud", BaudRate,   2'b11);
    check("cfg_app_pend", CfgPending, 1'b0);
    repeat (10) step();

    // Last write during WAIT wins.
    toggle_line(6);
    cfg_write(2'b11, 2'b00);
    toggle_line(10);
    cfg_write(2'b10, 2'b01);
    toggle_line(10);
    RxLine = 1;
    repeat (25) step();
    check("cfg2_par",  ParityType, 2'b10);
    check("cfg2_baud", BaudRate,   2'b01);
    check("cfg2_pend", CfgPending, 1'b0);
    repeat (10) step();

    // RxDone held high across reset release is not a frame.
    Reset = 1; RxDone = 1; RxData = 8'hEE;
    repeat (2) step();
    Reset = 0;
    repeat (6) step();
    check("done_hi_count", FifoCount, 0);
    check("done_hi_valid", OutValid,  1'b0);
    RxDone = 0;
    repeat (3) step();

    // Reset mid-operation drops buffered entries and pending config.
    for (int i = 0; i < 3; i++) frame(8'h31 + 8'(i), 1'b0, 1'b0, 1'b0);
    toggle_line(6);
    cfg_write(2'b01, 2'b01);
    step();
    check("pre_rst_count", FifoCount,  3);
    check("pre_rst_pend",  CfgPending, 1'b1);
    Reset = 1;
    step();
    check("mid_rst_count",  FifoCount,  0);
    check("mid_rst_pend",   CfgPending, 1'b0);
    check("mid_rst_parity", ParityType, 2'b00);
    check("mid_rst_baud",   BaudRate,   2'b10);
    Reset = 0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
